pipe_stage_skid: RTL and testbench

//  Parametrised pipeline-stage register for the pipelined MIPS datapath; replaces the per-stage registers.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_entry_reg.sv | 48 ++++
 rtl/pipe_stage_skid.sv | 116 +++++++++++
 tb/tb_pipe_stage_skid.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared widths, control-field layout and bubble encoding for the
//             MIPS pipeline-stage registers.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W_DEF = 32;
   localparam int unsigned PIPE_CTRL_W_DEF = 16;
   localparam int unsigned PIPE_OCC_W      = 2;

   // Payload widths of each inter-stage register
   localparam int unsigned PIPE_IFID_W  = 64;   // PC+4, instruction
   localparam int unsigned PIPE_IDEX_W  = 143;  // PC+4, rs, rt, imm, rs/rt/rd ids
   localparam int unsigned PIPE_EXMEM_W = 102;  // target, ALU result, rt, zero, rd id
   localparam int unsigned PIPE_MEMWB_W = 69;   // read data, ALU result, rd id

   localparam int unsigned CTRL_REGWRITE = 0;
   localparam int unsigned CTRL_MEMTOREG = 1;
   localparam int unsigned CTRL_MEMREAD  = 2;
   localparam int unsigned CTRL_MEMWRITE = 3;
   localparam int unsigned CTRL_BRANCH   = 4;
   localparam int unsigned CTRL_ALUSRC   = 5;
   localparam int unsigned CTRL_REGDST   = 6;
   localparam int unsigned CTRL_ALUOP_LO = 7;
   localparam int unsigned CTRL_ALUOP_HI = 8;
   localparam int unsigned CTRL_JUMP     = 9;

   localparam logic [PIPE_CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_MAIN  = 2'b10,
      SKID_FULL  = 2'b11
   } skid_state_e;

   function automatic logic ctrl_has_side_effects(input logic [PIPE_CTRL_W_DEF-1:0] ctrl);
      return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE]
           | ctrl[CTRL_BRANCH]   | ctrl[CTRL_JUMP];
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_entry_reg
//  Purpose  : One valid+data+ctrl holding register; clearing forces the
//             payload to zero and the control word to the bubble encoding.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W      = PIPE_DATA_W_DEF,
   parameter int unsigned       CTRL_W      = PIPE_CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   // Clear wins over load so a flush can never be overridden by a transfer
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= BUBBLE_CTRL;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_ctrl  <= i_ctrl;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Valid/ready pipeline-stage register with a 2-entry skid buffer,
//             backpressure stall and flush-to-bubble; in_ready is registered.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W      = PIPE_DATA_W_DEF,
   parameter int unsigned       CTRL_W      = PIPE_CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [CTRL_W-1:0]     in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic [PIPE_OCC_W-1:0] occupancy
);

   logic              w_main_valid;
   logic [DATA_W-1:0] w_main_data;
   logic [CTRL_W-1:0] w_main_ctrl;
   logic              w_skid_valid;
   logic [DATA_W-1:0] w_skid_data;
   logic [CTRL_W-1:0] w_skid_ctrl;

   logic              w_acc;
   logic              w_pop;
   logic              w_main_load;
   logic              w_main_clr;
   logic [DATA_W-1:0] w_main_d;
   logic [CTRL_W-1:0] w_main_c;
   logic              w_skid_load;
   logic              w_skid_clr;

   assign in_ready = ~w_skid_valid;
   assign w_acc    = in_valid & ~w_skid_valid & ~flush;
   assign w_pop    = w_main_valid & out_ready;

   always_comb begin
      w_main_load = 1'b0;
      w_main_clr  = 1'b0;
      w_main_d    = in_data;
      w_main_c    = in_ctrl;
      w_skid_load = 1'b0;
      w_skid_clr  = 1'b0;
      if (flush) begin
         w_main_clr = 1'b1;
         w_skid_clr = 1'b1;
      end else if (!w_main_valid) begin
         w_main_load = w_acc;
      end else if (w_pop) begin
         if (w_skid_valid) begin
            w_main_load = 1'b1;
            w_main_d    = w_skid_data;
            w_main_c    = w_skid_ctrl;
            w_skid_clr  = 1'b1;
         end else if (w_acc) begin
            w_main_load = 1'b1;
         end else begin
            // Emptying reloads the bubble encoding so stale payload never shows
            w_main_clr  = 1'b1;
         end
      end else if (w_acc) begin
         w_skid_load = 1'b1;
      end
   end

   pipe_entry_reg #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_CTRL (BUBBLE_CTRL)
   ) u_main (
      .clk     (clk),
      .rst     (reset),
      .i_clear (w_main_clr),
      .i_load  (w_main_load),
      .i_data  (w_main_d),
      .i_ctrl  (w_main_c),
      .o_valid (w_main_valid),
      .o_data  (w_main_data),
      .o_ctrl  (w_main_ctrl)
   );

   pipe_entry_reg #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_CTRL (BUBBLE_CTRL)
   ) u_skid (
      .clk     (clk),
      .rst     (reset),
      .i_clear (w_skid_clr),
      .i_load  (w_skid_load),
      .i_data  (in_data),
      .i_ctrl  (in_ctrl),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_data),
      .o_ctrl  (w_skid_ctrl)
   );

   assign out_valid = w_main_valid;
   assign out_data  = w_main_data;
   assign out_ctrl  = w_main_ctrl;
   assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Purpose  : Self-checking bench for pipe_stage_skid against a depth-2 queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

   localparam int unsigned     DW  = 32;
   localparam int unsigned     CW  = 16;
   localparam logic [CW-1:0]   BUB = 16'h8000;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;

   int n_tests = 0;
   int n_fail  = 0;
   int model_pops = 0;
   int dut_pops   = 0;
   bit model_on   = 1'b0;
   logic [CW+DW-1:0] mq[$];

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Model: the stage is a 2-deep FIFO; reset/flush empty it
   initial forever begin
      @(posedge clk);
      if (reset || flush) begin
         mq.delete();
      end else begin
         bit acc, pop;
         acc = in_valid && (mq.size() < 2);
         pop = (mq.size() > 0) && out_ready;
         if (pop) begin
            void'(mq.pop_front());
            model_pops++;
         end
         if (acc) mq.push_back({in_ctrl, in_data});
      end
      model_on = 1'b1;
   end

   initial begin
      logic          ps, exp_v;
      logic [DW-1:0] pd, exp_d;
      logic [CW-1:0] pc, exp_c;
      ps = 1'b0; pd = '0; pc = '0;
      forever begin
         @(negedge clk);
         if (model_on) begin
            exp_v = (mq.size() > 0);
            exp_d = exp_v ? mq[0][DW-1:0]     : '0;
            exp_c = exp_v ? mq[0][CW+DW-1:DW] : BUB;
            check("m_out_valid", 64'(out_valid), 64'(exp_v));
            check("m_out_data",  64'(out_data),  64'(exp_d));
            check("m_out_ctrl",  64'(out_ctrl),  64'(exp_c));
            check("m_in_ready",  64'(in_ready),  64'(mq.size() < 2));
            check("m_occupancy", 64'(occupancy), 64'(mq.size()));
            check("inv_skid_without_main", 64'(out_valid), 64'(occupancy != 2'd0));
            if (ps) begin
               check("stall_valid", 64'(out_valid), 64'd1);
               check("stall_data",  64'(out_data),  64'(pd));
               check("stall_ctrl",  64'(out_ctrl),  64'(pc));
            end
            if (out_valid && out_ready && !flush && !reset) dut_pops++;
            ps = out_valid && !out_ready && !flush && !reset;
            pd = out_data;
            pc = out_ctrl;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      cyc(); cyc();
      reset = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_ctrl",  64'(out_ctrl),  64'h8000);

      // Reset while stalled with both entries held
      in_valid = 1'b1; in_data = 32'hAAAA_0001; in_ctrl = 16'h0011;
      cyc();
      in_data = 32'hBBBB_0002; in_ctrl = 16'h0022;
      cyc();
      in_valid = 1'b0;
      check("full_occ",       64'(occupancy), 64'd2);
      check("full_in_ready",  64'(in_ready),  64'd0);
      check("full_head",      64'(out_data),  64'hAAAA_0001);
      check("model_depth",    64'(mq.size()), 64'd2);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_in_ready",  64'(in_ready),  64'd1);
      check("rst2_occ",       64'(occupancy), 64'd0);
      check("rst2_out_ctrl",  64'(out_ctrl),  64'h8000);
      check("rst2_out_data",  64'(out_data),  64'd0);

      // Streaming 1..10
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_data = 32'(i); in_ctrl = 16'(16'h0100 + i);
         cyc();
         check("stream_data",  64'(out_data),  64'(i));
         check("stream_ready", 64'(in_ready),  64'd1);
         check("stream_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      cyc();
      check("stream_drain_valid", 64'(out_valid), 64'd0);
      check("stream_drain_data",  64'(out_data),  64'd0);

      // Stall with A then B, then release
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h0000_000A; in_ctrl = 16'h000A;
      cyc();
      check("stall_a_occ", 64'(occupancy), 64'd1);
      in_data = 32'h0000_000B; in_ctrl = 16'h000B;
      cyc();
      in_valid = 1'b0;
      check("stall_ab_head",  64'(out_data),  64'hA);
      check("stall_ab_occ",   64'(occupancy), 64'd2);
      check("stall_ab_ready", 64'(in_ready),  64'd0);
      cyc();
      check("stall_hold_head", 64'(out_data), 64'hA);
      out_ready = 1'b1;
      cyc();
      check("release_b",       64'(out_data), 64'hB);
      check("release_b_ctrl",  64'(out_ctrl), 64'hB);
      check("release_ready",   64'(in_ready), 64'd1);
      cyc();
      check("release_empty",   64'(out_valid), 64'd0);

      // Flush while accepting C at occupancy 1
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h0000_0011; in_ctrl = 16'h0001;
      cyc();
      flush = 1'b1; in_data = 32'h0000_000C; in_ctrl = 16'h000C;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      check("flushacc_valid", 64'(out_valid), 64'd0);
      check("flushacc_data",  64'(out_data),  64'd0);
      check("flushacc_occ",   64'(occupancy), 64'd0);
      check("flushacc_ready", 64'(in_ready),  64'd1);
      cyc();
      check("flushacc_no_c",  64'(out_valid), 64'd0);

      // Flush with pop at occupancy 2
      in_valid = 1'b1; in_data = 32'h21; in_ctrl = 16'h21;
      cyc();
      in_data = 32'h22; in_ctrl = 16'h22;
      cyc();
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
      cyc();
      flush = 1'b0; out_ready = 1'b0;
      check("flushpop_occ", 64'(occupancy), 64'd0);
      in_valid = 1'b1; in_data = 32'h33; in_ctrl = 16'h33;
      cyc();
      in_valid = 1'b0;
      check("flushpop_next",     64'(out_data),  64'h33);
      check("flushpop_next_occ", 64'(occupancy), 64'd1);
      out_ready = 1'b1;
      cyc();
      check("flushpop_alone", 64'(out_valid), 64'd0);

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         reset     = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = in_valid ? DW'($urandom) : 'x;
         in_ctrl   = in_valid ? CW'($urandom) : 'x;
         cyc();
      end
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(); cyc(); cyc();
      check("sb_pop_count", 64'(dut_pops), 64'(model_pops));
      check("sb_drained",   64'(occupancy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
